// File: rtl/arb_pkg.sv
// Shared types for the arbitrating multiplexer.
//   arb_mode_e   : arbitration policy applied while no packet holds the grant
//   lock_state_e : whether a multi-beat packet currently owns the grant
package arb_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/rr_arbiter_n.sv
// Pure combinational N-way arbiter.
// Round-robin: first requester searching upward from ptr, wrapping N-1 -> 0.
// Fixed: lowest requesting index wins.
//   req       in  N     request vector
//   ptr       in  SELW  round-robin start index (ignored in fixed mode)
//   mode      in  1     arbitration policy
//   grant     out N     one-hot grant, zero when no request
//   grant_idx out SELW  index of the granted requester (0 when none)
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter  int unsigned N    = 4,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  arb_mode_e       mode,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    int unsigned cand;
    logic        found;

    // Walk candidates in priority order; the first requesting one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (mode == ARB_FIXED) ? k : 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && (cand == i) && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer with valid/ready handshakes, packet
// locking for multi-beat transfers and a single registered output stage.
//   clk, reset      clock and asynchronous active-high reset
//   mode            0 = round-robin, 1 = fixed priority (lowest index)
//   in_data         channel i at [i*WIDTH +: WIDTH]
//   in_valid/last   per-channel valid and end-of-packet flag
//   in_ready        per-channel ready, at most one bit set
//   out_data/sel    registered beat and index of its source channel
//   out_last        registered end-of-packet flag of that beat
//   out_valid/ready output handshake
module arb_mux_n
    import arb_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned N     = 4,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    lock_state_e       state;
    lock_state_e       state_nxt;
    logic [SELW-1:0]   lock_ch;
    logic [SELW-1:0]   rr_ptr;
    logic [SELW-1:0]   next_ptr;
    logic [N-1:0]      req_masked;
    logic [N-1:0]      grant;
    logic [SELW-1:0]   grant_idx;
    logic              can_accept;
    logic              accept;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_last;

    // Lock state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock on a non-final beat, release on the locked channel's final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (accept && !sel_last) state_nxt = LOCKED;
            LOCKED:   if (accept && sel_last)  state_nxt = UNLOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    // While locked only lock_ch may request, even if it is idle.
    always_comb begin
        req_masked = in_valid;
        if (state == LOCKED) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (SELW'(i) != lock_ch) begin
                    req_masked[i] = 1'b0;
                end
            end
        end
    end

    rr_arbiter_n #(
        .N (N)
    ) u_arb (
        .req       (req_masked),
        .ptr       (rr_ptr),
        .mode      (arb_mode_e'(mode)),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake: reset gates ready so nothing is taken while it is asserted.
    always_comb begin
        can_accept = !out_valid || out_ready;
        in_ready   = (reset || !can_accept) ? '0 : grant;
        accept     = |(in_valid & in_ready);
    end

    // One-hot AND-OR select of the granted channel's beat.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
                sel_last = sel_last | in_last[i];
            end
        end
    end

    assign next_ptr = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);

    // Output register, lock channel and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_ch   <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= grant_idx;
                out_last  <= sel_last;
                if (state == UNLOCKED && !sel_last) begin
                    lock_ch <= grant_idx;
                end
                if (sel_last && (mode == ARB_RR)) begin
                    rr_ptr <= next_ptr;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: a cycle-level reference model checked
// on every falling edge, plus directed scenarios with literal expectations.
module tb_arb_mux_n;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic           mode      = 1'b0;
    logic [N*W-1:0] in_data   = '0;
    logic [N-1:0]   in_valid  = '0;
    logic [N-1:0]   in_last   = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_last;
    logic           out_valid;
    logic           out_ready = 1'b1;

    logic [23:0]    b_in_data  = '0;
    logic [2:0]     b_in_valid = '0;
    logic [2:0]     b_in_last  = '0;
    logic [2:0]     b_in_ready;
    logic [7:0]     b_out_data;
    logic [1:0]     b_out_sel;
    logic           b_out_last;
    logic           b_out_valid;
    logic           b_out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_mux_n #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    arb_mux_n #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .reset(reset), .mode(mode),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_sel(b_out_sel),
        .out_last(b_out_last), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: what the output register must hold after the next edge.
    int          m_rr = 0;
    int          m_lch = 0;
    bit          m_locked = 0;
    bit          m_valid = 0;
    bit          m_last = 0;
    int          m_sel = 0;
    logic [W-1:0] m_data = '0;

    always @(negedge clk) begin
        int g;
        int c;
        logic [N-1:0] exp_rdy;
        if (reset) begin
            m_rr = 0; m_lch = 0; m_locked = 0;
            m_valid = 0; m_last = 0; m_sel = 0; m_data = '0;
        end
        chk("m_out_valid", out_valid, m_valid);
        chk("m_out_data", out_data, m_data);
        chk("m_out_sel", out_sel, m_sel);
        chk("m_out_last", out_last, m_last);

        g = -1;
        if (!reset && (!m_valid || out_ready)) begin
            if (m_locked) begin
                if (in_valid[m_lch]) g = m_lch;
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = mode ? k : (m_rr + k) % N;
                    if (g < 0 && in_valid[c]) g = c;
                end
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("m_in_ready", in_ready, exp_rdy);

        if (!reset) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = in_data[g*W +: W];
                m_sel   = g;
                m_last  = in_last[g];
                if (in_last[g]) begin
                    m_locked = 0;
                    if (!mode) m_rr = (g + 1) % N;
                end else begin
                    m_locked = 1;
                    m_lch    = g;
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    int rr_seq[5] = '{0, 1, 2, 3, 0};
    int b_seq[4]  = '{0, 1, 2, 0};

    initial begin
        // Reset: outputs cleared and nothing accepted despite valid inputs.
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'(i * 16'h1111);
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 4'b0000);

        // Round-robin fairness.
        reset = 1'b0;
        #1;
        chk("rr_first_ready", in_ready, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_sel", out_sel, rr_seq[i]);
            chk("rr_data", out_data, 64'(rr_seq[i] * 16'h1111));
            chk("rr_valid", out_valid, 1);
        end
        in_valid = '0;
        step();
        chk("rr_drain", out_valid, 0);

        // Fixed priority.
        mode     = 1'b1;
        in_valid = 4'b1110;
        #1;
        chk("fix_ready0", in_ready, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fix_sel", out_sel, 1);
            chk("fix_ready", in_ready, 4'b0010);
        end
        in_valid = '0;
        mode     = 1'b0;
        step();

        // Packet lock on ch2 with ch0 waiting, including an idle cycle.
        in_data[2*W +: W] = 16'h2A01;
        in_data[0*W +: W] = 16'h0F0F;
        in_last  = 4'b0000;
        in_valid = 4'b0101;
        #1;
        chk("lock_ready1", in_ready, 4'b0100);
        step();
        chk("lock_sel1", out_sel, 2);
        chk("lock_data1", out_data, 16'h2A01);
        chk("lock_last1", out_last, 0);
        in_valid = 4'b0001;
        #1;
        chk("lock_idle_ready", in_ready, 4'b0000);
        step();
        chk("lock_idle_valid", out_valid, 0);
        in_valid = 4'b0101;
        in_data[2*W +: W] = 16'h2A02;
        #1;
        chk("lock_ready2", in_ready, 4'b0100);
        step();
        chk("lock_data2", out_data, 16'h2A02);
        in_data[2*W +: W] = 16'h2A03;
        in_last = 4'b0100;
        #1;
        chk("lock_ready3", in_ready, 4'b0100);
        step();
        chk("lock_data3", out_data, 16'h2A03);
        chk("lock_sel3", out_sel, 2);
        chk("lock_last3", out_last, 1);
        in_valid = 4'b0001;
        in_last  = 4'b0001;
        #1;
        chk("unlock_ready", in_ready, 4'b0001);
        step();
        chk("unlock_sel", out_sel, 0);
        chk("unlock_data", out_data, 16'h0F0F);
        in_valid = '0;
        step();

        // Backpressure holds the pending beat and blocks all inputs.
        in_data[0*W +: W] = 16'hABCD;
        in_valid = 4'b0001;
        step();
        chk("bp_first", out_data, 16'hABCD);
        out_ready = 1'b0;
        in_data[0*W +: W] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", in_ready, 4'b0000);
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 16'hABCD);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'b0001);
        step();
        chk("bp_next", out_data, 16'h1234);
        in_valid = '0;
        step();
        chk("bp_nodup", out_valid, 0);

        // Asynchronous reset during a locked ch1 packet.
        in_data[1*W +: W] = 16'h1B01;
        in_valid = 4'b0010;
        in_last  = 4'b0000;
        step();
        chk("ar_sel", out_sel, 1);
        chk("ar_valid_pre", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid_now", out_valid, 0);
        chk("ar_ready_now", in_ready, 4'b0000);
        step();
        reset    = 1'b0;
        mode     = 1'b0;
        in_data[0*W +: W] = 16'h0A0A;
        in_data[1*W +: W] = 16'h1B1B;
        in_valid = 4'b0011;
        in_last  = 4'b0011;
        #1;
        chk("ar_post_ready", in_ready, 4'b0001);
        step();
        chk("ar_post_sel0", out_sel, 0);
        chk("ar_post_data0", out_data, 16'h0A0A);
        step();
        chk("ar_post_sel1", out_sel, 1);
        chk("ar_post_data1", out_data, 16'h1B1B);
        in_valid = '0;
        step();

        // N=3, WIDTH=8 wraps 2 -> 0.
        b_in_data  = {8'h22, 8'h11, 8'h00};
        b_in_last  = 3'b111;
        b_in_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("n3_sel", b_out_sel, b_seq[i]);
            chk("n3_data", b_out_data, 64'(b_seq[i] * 8'h11));
        end
        b_in_valid = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
